// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the keypad digit buffer.
// Used by the buffer, its interface and the key edge detector.
package keypad_pkg;

    localparam logic [4:0] KEY_NONE = 5'd16;

    typedef logic [4:0] key_code_t;

    typedef enum logic {
        FP_SHIFT    = 1'b0,
        FP_SATURATE = 1'b1
    } full_policy_e;

endpackage

// File: rtl/keypad_seq_buffer_if.sv
// keypad_seq_buffer_if: key inputs and buffer outputs of the digit buffer.
// master drives keys/strobes, slave is the buffer itself.
interface keypad_seq_buffer_if #(
    parameter int DIGIT_W = 4,
    parameter int DEPTH   = 8
);
    import keypad_pkg::*;

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                       key_en;
    key_code_t                  key_code;
    logic                       bksp;
    logic                       clr;
    logic [DEPTH*DIGIT_W-1:0]   seq;
    logic [CNT_W-1:0]           count;
    logic                       full;
    logic                       accept;
    logic                       ovf;

    modport master (
        output key_en, key_code, bksp, clr,
        input  seq, count, full, accept, ovf
    );

    modport slave (
        input  key_en, key_code, bksp, clr,
        output seq, count, full, accept, ovf
    );

endinterface

// File: rtl/keypad_seq_buffer_key_edge_det.sv
// key_edge_det: one event per rising edge of a key-qualified level.
// A rising edge carrying KEY_NONE is swallowed without retry.
module key_edge_det
    import keypad_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      key_en,
    input  key_code_t key_code,
    output logic      evt
);

    logic key_en_q;

    // Remember last key level so a held key fires only once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) key_en_q <= 1'b0;
        else        key_en_q <= key_en;
    end

    assign evt = key_en && !key_en_q && (key_code != KEY_NONE);

endmodule

// File: rtl/keypad_seq_buffer.sv
// keypad_seq_buffer: DEPTH-slot digit buffer, newest digit in the low slot.
// Optional idle auto-clear is built in with `define KEYPAD_SEQ_TIMEOUT_EN.
module keypad_seq_buffer
    import keypad_pkg::*;
#(
    parameter int           DIGIT_W     = 4,
    parameter int           DEPTH       = 8,
    parameter full_policy_e SAT_MODE    = FP_SHIFT,
    parameter int           TIMEOUT_CYC = 10000
) (
    input logic                clk,
    input logic                rst_n,
    keypad_seq_buffer_if.slave bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SEQ_W = DEPTH * DIGIT_W;

    logic [SEQ_W-1:0]   seq_q, seq_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic               evt;
    logic               is_full;
    logic               tmo;
    logic [DIGIT_W-1:0] digit;

    key_edge_det u_edge (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_en   (bus.key_en),
        .key_code (bus.key_code),
        .evt      (evt)
    );

    assign digit   = bus.key_code[DIGIT_W-1:0];
    assign is_full = (cnt_q == CNT_W'(DEPTH));

`ifdef KEYPAD_SEQ_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

    logic [IDLE_W-1:0] idle_q;
    logic              user_act;

    assign user_act = bus.clr || bus.bksp || evt;
    assign tmo = !user_act && (idle_q == IDLE_W'(TIMEOUT_CYC - 1));

    // Count idle cycles while digits are held; any activity restarts it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            idle_q <= '0;
        else if (user_act || tmo || cnt_q == '0)
            idle_q <= '0;
        else
            idle_q <= idle_q + IDLE_W'(1);
    end
`else
    assign tmo = 1'b0;
`endif

    // Next buffer state; clr beats bksp beats a key event
    always_comb begin
        seq_d = seq_q;
        cnt_d = cnt_q;
        acc_d = 1'b0;
        ovf_d = ovf_q;
        if (bus.clr || tmo) begin
            seq_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (bus.bksp) begin
            if (cnt_q != '0) begin
                seq_d = seq_q >> DIGIT_W;
                cnt_d = cnt_q - CNT_W'(1);
            end
        end else if (evt) begin
            if (is_full) ovf_d = 1'b1;
            if (!is_full || SAT_MODE == FP_SHIFT) begin
                seq_d = {seq_q[SEQ_W-DIGIT_W-1:0], digit};
                acc_d = 1'b1;
            end
            if (!is_full) cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Buffer state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_q <= '0;
            cnt_q <= '0;
            acc_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            seq_q <= seq_d;
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end
    end

    assign bus.seq    = seq_q;
    assign bus.count  = cnt_q;
    assign bus.full   = is_full;
    assign bus.accept = acc_q;
    assign bus.ovf    = ovf_q;

endmodule

// File: tb/tb_keypad_seq_buffer.sv
// tb_keypad_seq_buffer: directed checks of the digit buffer.
// Three instances: DEPTH 8 shift, DEPTH 4 shift, DEPTH 4 saturate.
module tb_keypad_seq_buffer;
    import keypad_pkg::*;

    logic      clk = 1'b0;
    logic      rst_n;
    logic      key_en;
    key_code_t key_code;
    logic      bksp;
    logic      clr;

    int checks = 0;
    int errs   = 0;
    int acc8   = 0;
    int acc4s  = 0;
    int acc4r  = 0;
    int a0;
    int b0;

    keypad_seq_buffer_if #(.DIGIT_W(4), .DEPTH(8)) b8 ();
    keypad_seq_buffer_if #(.DIGIT_W(4), .DEPTH(4)) b4s ();
    keypad_seq_buffer_if #(.DIGIT_W(4), .DEPTH(4)) b4r ();

    assign b8.key_en    = key_en;
    assign b8.key_code  = key_code;
    assign b8.bksp      = bksp;
    assign b8.clr       = clr;
    assign b4s.key_en   = key_en;
    assign b4s.key_code = key_code;
    assign b4s.bksp     = bksp;
    assign b4s.clr      = clr;
    assign b4r.key_en   = key_en;
    assign b4r.key_code = key_code;
    assign b4r.bksp     = bksp;
    assign b4r.clr      = clr;

`ifdef KEYPAD_SEQ_TIMEOUT_EN
    localparam int TMO = 50;
`else
    localparam int TMO = 10000;
`endif

    keypad_seq_buffer #(
        .DIGIT_W(4), .DEPTH(8), .SAT_MODE(FP_SHIFT), .TIMEOUT_CYC(TMO)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(b8)
    );

    keypad_seq_buffer #(
        .DIGIT_W(4), .DEPTH(4), .SAT_MODE(FP_SHIFT), .TIMEOUT_CYC(TMO)
    ) u_d4s (
        .clk(clk), .rst_n(rst_n), .bus(b4s)
    );

    keypad_seq_buffer #(
        .DIGIT_W(4), .DEPTH(4), .SAT_MODE(FP_SATURATE), .TIMEOUT_CYC(TMO)
    ) u_d4r (
        .clk(clk), .rst_n(rst_n), .bus(b4r)
    );

    always #5 clk = ~clk;

    // Tally accept pulses away from the active edge
    always @(negedge clk) begin
        if (b8.accept)  acc8++;
        if (b4s.accept) acc4s++;
        if (b4r.accept) acc4r++;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic press(input key_code_t c);
        @(negedge clk);
        key_en = 1'b1;
        key_code = c;
        repeat (3) @(negedge clk);
        key_en = 1'b0;
        key_code = KEY_NONE;
        repeat (2) @(negedge clk);
    endtask

    task automatic strobe(input logic b, input logic c);
        @(negedge clk);
        bksp = b;
        clr = c;
        @(negedge clk);
        bksp = 1'b0;
        clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        key_en = 1'b0;
        key_code = KEY_NONE;
        bksp = 1'b0;
        clr = 1'b0;
        #3;
        chk("rst_seq", 64'(b8.seq), 64'h0);
        chk("rst_count", 64'(b8.count), 64'h0);
        chk("rst_accept", 64'(b8.accept), 64'h0);
        chk("rst_ovf", 64'(b8.ovf), 64'h0);
        chk("rst_full", 64'(b8.full), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        press(5'd1);
        press(5'd2);
        press(5'd3);
        chk("k123_seq", 64'(b8.seq), 64'h123);
        chk("k123_count", 64'(b8.count), 64'd3);
        chk("k123_acc", 64'(acc8), 64'd3);
        chk("k123_ovf", 64'(b8.ovf), 64'h0);

        press(5'd4);
        chk("d4s_full4", 64'(b4s.full), 64'h1);
        chk("d4s_ovf4", 64'(b4s.ovf), 64'h0);
        press(5'd5);
        chk("d4s_seq", 64'(b4s.seq), 64'h2345);
        chk("d4s_count", 64'(b4s.count), 64'd4);
        chk("d4s_ovf", 64'(b4s.ovf), 64'h1);
        chk("d4s_acc", 64'(acc4s), 64'd5);
        chk("d4r_seq", 64'(b4r.seq), 64'h1234);
        chk("d4r_count", 64'(b4r.count), 64'd4);
        chk("d4r_ovf", 64'(b4r.ovf), 64'h1);
        chk("d4r_acc", 64'(acc4r), 64'd4);
        chk("d8_seq5", 64'(b8.seq), 64'h12345);

        strobe(1'b0, 1'b1);
        chk("clr_seq", 64'(b4s.seq), 64'h0);
        chk("clr_count", 64'(b4s.count), 64'd0);
        chk("clr_ovf", 64'(b4s.ovf), 64'h0);
        chk("clr_ovf_r", 64'(b4r.ovf), 64'h0);

        press(5'd1);
        press(5'd2);
        press(5'd3);
        a0 = acc8;
        strobe(1'b1, 1'b0);
        strobe(1'b1, 1'b0);
        chk("bk2_seq", 64'(b8.seq), 64'h1);
        chk("bk2_count", 64'(b8.count), 64'd1);
        chk("bk_noacc", 64'(acc8 - a0), 64'd0);

        press(5'd2);
        press(5'd3);
        strobe(1'b1, 1'b1);
        chk("bkclr_seq", 64'(b8.seq), 64'h0);
        chk("bkclr_count", 64'(b8.count), 64'd0);

        strobe(1'b1, 1'b0);
        chk("bk0_seq", 64'(b8.seq), 64'h0);
        chk("bk0_count", 64'(b8.count), 64'd0);

        a0 = acc8;
        @(negedge clk);
        key_en = 1'b1;
        key_code = KEY_NONE;
        repeat (3) @(negedge clk);
        key_code = 5'd7;
        repeat (3) @(negedge clk);
        key_en = 1'b0;
        repeat (2) @(negedge clk);
        chk("none_count", 64'(b8.count), 64'd0);
        chk("none_acc", 64'(acc8 - a0), 64'd0);

        @(negedge clk);
        key_en = 1'b1;
        key_code = 5'd7;
        repeat (20) @(negedge clk);
        key_en = 1'b0;
        repeat (2) @(negedge clk);
        chk("hold_acc", 64'(acc8 - a0), 64'd1);
        chk("hold_count", 64'(b8.count), 64'd1);
        chk("hold_seq", 64'(b8.seq), 64'h7);

        press(5'd21);
        chk("hibit_seq", 64'(b8.seq), 64'h75);

        @(negedge clk);
        key_en = 1'b1;
        key_code = 5'd9;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_seq", 64'(b8.seq), 64'h0);
        chk("arst_count", 64'(b8.count), 64'd0);
        chk("arst_acc", 64'(b8.accept), 64'h0);
        key_en = 1'b0;
        key_code = KEY_NONE;
        @(negedge clk);
        rst_n = 1'b1;
        press(5'd4);
        chk("post_rst_seq", 64'(b8.seq), 64'h4);
        chk("post_rst_count", 64'(b8.count), 64'd1);

`ifdef KEYPAD_SEQ_TIMEOUT_EN
        strobe(1'b0, 1'b1);
        @(negedge clk);
        key_en = 1'b1;
        key_code = 5'd5;
        @(negedge clk);
        key_en = 1'b0;
        key_code = KEY_NONE;
        chk("tmo_start", 64'(b8.count), 64'd1);
        repeat (49) @(negedge clk);
        chk("tmo_49", 64'(b8.count), 64'd1);
        @(negedge clk);
        chk("tmo_50", 64'(b8.count), 64'd0);

        @(negedge clk);
        key_en = 1'b1;
        key_code = 5'd5;
        @(negedge clk);
        key_en = 1'b0;
        key_code = KEY_NONE;
        repeat (49) @(negedge clk);
        key_en = 1'b1;
        key_code = 5'd6;
        @(negedge clk);
        key_en = 1'b0;
        key_code = KEY_NONE;
        chk("tmo_key_count", 64'(b8.count), 64'd2);
        chk("tmo_key_seq", 64'(b8.seq), 64'h56);
`endif

        b0 = errs;
        $display("Result: errors=%0d of %0d checks", b0, checks);
        $finish;
    end

endmodule

// File: doc/keypad_seq_buffer.md
Name: keypad_seq_buffer

Overview:
- Parametrised successor to the single-shot keypad digit shift register in the lock datapath.
- Captures up to DEPTH key digits of DIGIT_W bits each. Newest digit sits in the least-significant slot.
- Tracks the number of digits held, and supports backspace, clear and a selectable full-buffer policy.
- Feeds the lock comparator: `seq` and `count` give it the entered code.

Parameters:
- DIGIT_W, 4, bits per stored digit; taken from key_code[DIGIT_W-1:0]; legal range 1..4.
- DEPTH, 8, number of digit slots; must be ≥ 2.
- SAT_MODE, 0, full-buffer policy. 0 = shift the oldest digit out. 1 = reject the new digit.
- TIMEOUT_CYC, 10000, idle cycles before auto-clear; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  one clock; reset is asynchronous and active-low.
- key_en  in  1  key-qualified level from the keypad scanner; one key event per rising edge.
- key_code  in  5  key code; 0..15 are digits, 16 (KEY_NONE) means no key.
- bksp  in  1  single-cycle strobe; delete the newest digit.
- clr  in  1  single-cycle strobe; empty the buffer.
- seq  out  DEPTH*DIGIT_W  stored digits, newest in [DIGIT_W-1:0]; unused slots are 0.
- count  out  $clog2(DEPTH+1)  number of valid digits, 0..DEPTH.
- full  out  1  high when count == DEPTH (combinational from count).
- accept  out  1  one-cycle pulse on each digit written.
- ovf  out  1  sticky; set when a digit is dropped or rejected while full; cleared by clr or reset.

Behaviour:
- Reset (rst_n low, asynchronous):
  - seq = 0, count = 0, accept = 0, ovf = 0, key_en_q = 0.
  - Idle counter = 0 when built in.
- Key event:
  - A key event occurs in the cycle where key_en = 1, key_en_q = 0 and key_code != 16.
  - key_en_q is the registered key_en.
  - A held key produces exactly one event.
  - key_code == 16 on the rising edge consumes that edge: no event, and no retry while key_en stays high.
- Priority per cycle: clr > bksp > key event. Lower-priority requests in the same cycle are discarded, not queued.
- clr: seq = 0, count = 0, ovf = 0, accept = 0.
- bksp:
  - If count > 0: seq = seq >> DIGIT_W (zero fill at the top), count − 1.
  - If count == 0: no change.
  - accept = 0.
- Key event with count < DEPTH: seq = {seq[upper], digit}, count + 1, accept = 1.
- Key event with count == DEPTH, SAT_MODE = 0:
  - Shift anyway; the oldest digit is lost.
  - count stays DEPTH, accept = 1, ovf = 1.
- Key event with count == DEPTH, SAT_MODE = 1: seq and count unchanged, accept = 0, ovf = 1.
- Latency: seq, count and accept update at the clock edge where the event is detected. One cycle after key_en rises, results are visible on the outputs.
- Digit bits above DIGIT_W are ignored.
- Reset asserted mid-entry: the buffer is lost and no event is pending after release. If key_en is already high at release, no event occurs until it falls and rises again, because key_en_q is updated to the current key_en.

Optional Feature:
- Macro KEYPAD_SEQ_TIMEOUT_EN.
- Defined:
  - An idle counter increments every cycle while count > 0 and no clr/bksp/key event occurs.
  - It resets to 0 on any such event and when count == 0.
  - When it reaches TIMEOUT_CYC − 1, the next edge performs a clr (ovf cleared) and the counter returns to 0.
  - A user clr/bksp/key event in that same cycle takes precedence and resets the counter.
- Not defined: no counter, no auto-clear; TIMEOUT_CYC is unused.

Decomposition:
- Package keypad_pkg holds:
  - localparam KEY_NONE = 5'd16
  - typedef key_code_t (logic [4:0])
  - enum full_policy_e {FP_SHIFT = 0, FP_SATURATE = 1}, used for SAT_MODE.
- Sub-module key_edge_det: registers key_en and outputs the single-cycle event qualifier. It is reusable by the comparator's enter key.

Test Plan:
- Reset, then keys 1, 2, 3 (each key_en high 3 cycles, low 2) -> seq[11:0] = 0x123, count = 3, accept 3 single pulses, ovf = 0.
- DEPTH = 4, SAT_MODE = 0, keys 1..5 -> seq = 0x2345, count = 4, full = 1, ovf = 1 after the 5th key.
- DEPTH = 4, SAT_MODE = 1, keys 1..5 -> seq = 0x1234, no accept pulse on the 5th key, ovf = 1.
- From seq = 0x123 / count = 3:
  - bksp twice -> seq = 0x1, count = 1.
  - bksp then clr in the same cycle -> seq = 0, count = 0.
  - bksp at count 0 -> no change.
- key_en rising with key_code = 16, and key_en held 20 cycles with code 7 -> no event for code 16; exactly one accept for 7. rst_n pulsed low mid-entry -> all outputs 0 immediately (asynchronous).
- With KEYPAD_SEQ_TIMEOUT_EN, TIMEOUT_CYC = 50, one key then idle -> buffer clears exactly 50 cycles after the accept. A key at cycle 49 -> no clear; count = 2.
